// File: rtl/sudoku_checker.sv
// Sudoku board checker: scans rows, columns, then boxes one cell per clock,
// stopping at the first empty, out-of-range or duplicate value.
module sudoku_checker #(
    parameter int BOX = 3,
    parameter int VW  = 4
) (
    input  logic                           clka,
    input  logic                           restart_n,
    input  logic                           dp_check,
    input  logic [BOX*BOX*BOX*BOX*VW-1:0]  board,
    output logic                           busy,
    output logic                           done,
    output logic                           solved,
    output logic [1:0]                     fail_kind,
    output logic [7:0]                     fail_idx
);

    localparam int N  = BOX * BOX;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = 8;
    localparam int SW = 1 << VW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic            r_check_q;
    logic [1:0]      r_phase;
    logic [CW-1:0]   r_group;
    logic [CW-1:0]   r_elem;
    logic [SW-1:0]   r_seen;
    logic            r_solved;
    logic [1:0]      r_fail_kind;
    logic [IW-1:0]   r_fail_idx;

    logic            w_start;
    logic [CW-1:0]   w_row;
    logic [CW-1:0]   w_col;
    logic [IW-1:0]   w_idx;
    logic [VW-1:0]   w_val;
    logic            w_fail;
    logic            w_elem_end;
    logic            w_group_end;
    logic            w_last;

    assign w_start = dp_check & ~r_check_q & (r_state == S_IDLE);

    // Map scan counters to the board coordinate of the current cell
    always_comb begin
        w_row = '0;
        w_col = '0;
        case (r_phase)
            2'd0: begin
                w_row = r_group;
                w_col = r_elem;
            end
            2'd1: begin
                w_row = r_elem;
                w_col = r_group;
            end
            default: begin
                w_row = CW'((r_group / CW'(BOX)) * CW'(BOX)
                      + r_elem / CW'(BOX));
                w_col = CW'((r_group % CW'(BOX)) * CW'(BOX)
                      + r_elem % CW'(BOX));
            end
        endcase
    end

    assign w_idx = IW'(w_row) * IW'(N) + IW'(w_col);
    assign w_val = board[int'(w_idx)*VW +: VW];

    assign w_fail = (w_val == '0)
                 || (w_val > VW'(N))
                 || r_seen[w_val];

    assign w_elem_end  = (r_elem == CW'(N-1));
    assign w_group_end = (r_group == CW'(N-1));
    assign w_last      = (r_phase == 2'd2) && w_group_end && w_elem_end;

    // State register
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; the scan always ends at the last box cell, so a
    // board that changes mid-scan still terminates
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_next = S_SCAN;
            S_SCAN: if (w_fail || w_last) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State-decoded outputs; busy falls on the same edge done rises
    always_comb begin
        busy = (r_state == S_SCAN);
        done = (r_state == S_DONE);
    end

    assign solved    = r_solved;
    assign fail_kind = r_fail_kind;
    assign fail_idx  = r_fail_idx;

    // Scan datapath: counters, seen-mask and held result
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            r_check_q   <= 1'b0;
            r_phase     <= '0;
            r_group     <= '0;
            r_elem      <= '0;
            r_seen      <= '0;
            r_solved    <= 1'b0;
            r_fail_kind <= '0;
            r_fail_idx  <= '0;
        end else begin
            r_check_q <= dp_check;
            if (w_start) begin
                r_phase     <= '0;
                r_group     <= '0;
                r_elem      <= '0;
                r_seen      <= '0;
                r_solved    <= 1'b0;
                r_fail_kind <= '0;
                r_fail_idx  <= '0;
            end else if (r_state == S_SCAN) begin
                if (w_fail) begin
                    r_solved    <= 1'b0;
                    r_fail_kind <= r_phase + 2'd1;
                    r_fail_idx  <= w_idx;
                end else if (w_last) begin
                    r_solved <= 1'b1;
                end
                if (w_elem_end) begin
                    r_seen <= '0;
                end else begin
                    r_seen[w_val] <= 1'b1;
                end
                if (w_elem_end) begin
                    r_elem <= '0;
                    if (w_group_end) begin
                        r_group <= '0;
                        r_phase <= r_phase + 2'd1;
                    end else begin
                        r_group <= r_group + CW'(1);
                    end
                end else begin
                    r_elem <= r_elem + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sudoku_checker.sv
// Self-checking bench for sudoku_checker: directed cases plus random
// boards on 4x4 and 9x9 instances, checked against a reference model.
module tb_sudoku_checker;

    logic         clka = 1'b0;
    logic         restart_n;
    logic         dp4, dp9;
    logic [63:0]  b4;
    logic [323:0] b9;
    logic         busy4, done4, solved4;
    logic [1:0]   kind4;
    logic [7:0]   idx4;
    logic         busy9, done9, solved9;
    logic [1:0]   kind9;
    logic [7:0]   idx9;

    int n_cmp = 0;
    int n_err = 0;
    int cells[81];

    sudoku_checker #(.BOX(2), .VW(4)) u4 (
        .clka(clka), .restart_n(restart_n), .dp_check(dp4), .board(b4),
        .busy(busy4), .done(done4), .solved(solved4),
        .fail_kind(kind4), .fail_idx(idx4)
    );

    sudoku_checker #(.BOX(3), .VW(4)) u9 (
        .clka(clka), .restart_n(restart_n), .dp_check(dp9), .board(b9),
        .busy(busy9), .done(done9), .solved(solved9),
        .fail_kind(kind9), .fail_idx(idx9)
    );

    always #5 clka = ~clka;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic g_busy(input int sel);
        return sel != 0 ? busy9 : busy4;
    endfunction
    function automatic logic g_done(input int sel);
        return sel != 0 ? done9 : done4;
    endfunction
    function automatic logic g_solved(input int sel);
        return sel != 0 ? solved9 : solved4;
    endfunction
    function automatic logic [1:0] g_kind(input int sel);
        return sel != 0 ? kind9 : kind4;
    endfunction
    function automatic logic [7:0] g_idx(input int sel);
        return sel != 0 ? idx9 : idx4;
    endfunction

    task automatic set_dp(input int sel, input logic v);
        if (sel != 0) dp9 = v;
        else dp4 = v;
    endtask

    // First failing cell by the checking rules; pos is scan step index
    function automatic void ref_model(input int bx, output int kind,
                                      output int idx, output int pos);
        int n;
        int used[16];
        int r, c, v;
        n = bx * bx;
        for (int p = 0; p < 3; p++) begin
            for (int g = 0; g < n; g++) begin
                foreach (used[u]) used[u] = 0;
                for (int e = 0; e < n; e++) begin
                    if (p == 0) begin r = g; c = e; end
                    else if (p == 1) begin r = e; c = g; end
                    else begin
                        r = (g / bx) * bx + e / bx;
                        c = (g % bx) * bx + e % bx;
                    end
                    v = cells[r*n+c];
                    if (v == 0 || v > n || used[v] != 0) begin
                        kind = p + 1;
                        idx = r * n + c;
                        pos = p * n * n + g * n + e;
                        return;
                    end
                    used[v] = 1;
                end
            end
        end
        kind = 0;
        idx = 0;
        pos = 3 * n * n - 1;
    endfunction

    task automatic gen_valid(input int bx, input bit shuffle);
        int n, t, k;
        int perm[9];
        n = bx * bx;
        for (int i = 0; i < n; i++) perm[i] = i + 1;
        if (shuffle) begin
            for (int i = n - 1; i > 0; i--) begin
                k = int'($urandom_range(0, i));
                t = perm[i]; perm[i] = perm[k]; perm[k] = t;
            end
        end
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                cells[r*n+c] = perm[(bx*(r%bx) + r/bx + c) % n];
    endtask

    task automatic pack(input int bx);
        if (bx == 2) begin
            for (int i = 0; i < 16; i++) b4[i*4 +: 4] = 4'(cells[i]);
        end else begin
            for (int i = 0; i < 81; i++) b9[i*4 +: 4] = 4'(cells[i]);
        end
    endtask

    task automatic load4(input logic [63:0] rows);
        for (int i = 0; i < 16; i++) cells[i] = int'(rows[63-4*i -: 4]);
        pack(2);
    endtask

    // Start a scan, wait for done, check latency and held result
    task automatic run(input int sel, input int epos, input int ekind,
                       input int eidx, input bit hold, input int poke);
        int n;
        int stray;
        @(negedge clka);
        set_dp(sel, 1'b1);
        @(negedge clka);
        chk("busy_at_start", 32'(g_busy(sel)), 1);
        chk("no_done_at_start", 32'(g_done(sel)), 0);
        if (!hold) set_dp(sel, 1'b0);
        n = 0;
        while (g_done(sel) !== 1'b1 && n < 300) begin
            @(negedge clka);
            n++;
            if (poke != 0 && n == poke) set_dp(sel, 1'b1);
            if (poke != 0 && n == poke + 1) set_dp(sel, 1'b0);
        end
        chk("done_latency", 32'(n), 32'(epos + 1));
        chk("solved", 32'(g_solved(sel)), 32'(ekind == 0));
        chk("fail_kind", 32'(g_kind(sel)), 32'(ekind));
        chk("fail_idx", 32'(g_idx(sel)), 32'(eidx));
        chk("busy_drops_with_done", 32'(g_busy(sel)), 0);
        @(negedge clka);
        chk("done_one_cycle", 32'(g_done(sel)), 0);
        chk("kind_holds", 32'(g_kind(sel)), 32'(ekind));
        if (hold || poke != 0) begin
            stray = 0;
            repeat (60) begin
                @(negedge clka);
                if (g_busy(sel) !== 1'b0 || g_done(sel) !== 1'b0)
                    stray++;
            end
            chk("no_second_scan", 32'(stray), 0);
            set_dp(sel, 1'b0);
        end
    endtask

    initial begin
        int k, idx, pos, mode, a, b, t, bx, n, stray;
        restart_n = 1'b0;
        dp4 = 1'b0;
        dp9 = 1'b0;
        b4 = '0;
        b9 = '0;
        #12;
        chk("rst_busy", 32'(busy4), 0);
        chk("rst_done", 32'(done4), 0);
        chk("rst_solved", 32'(solved4), 0);
        chk("rst_kind", 32'(kind4), 0);
        chk("rst_idx", 32'(idx4), 0);
        chk("rst_busy9", 32'(busy9), 0);
        @(negedge clka);
        restart_n = 1'b1;

        load4(64'h1234_3412_2143_4321);
        run(0, 47, 0, 0, 0, 0);
        load4(64'h1134_3412_2143_4321);
        run(0, 1, 1, 1, 0, 0);
        load4(64'h1234_1234_3412_4321);
        run(0, 17, 2, 4, 0, 0);
        load4(64'h1234_2341_3412_4123);
        run(0, 34, 3, 4, 0, 0);
        load4(64'h1234_3012_2143_4321);
        run(0, 5, 1, 5, 0, 0);
        load4(64'h1234_3712_2143_4321);
        run(0, 5, 1, 5, 0, 0);

        load4(64'h1234_3412_2143_4321);
        @(negedge clka);
        dp4 = 1'b1;
        @(negedge clka);
        dp4 = 1'b0;
        repeat (9) @(negedge clka);
        restart_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy4), 0);
        chk("abort_done", 32'(done4), 0);
        chk("abort_solved", 32'(solved4), 0);
        chk("abort_kind", 32'(kind4), 0);
        chk("abort_idx", 32'(idx4), 0);
        @(negedge clka);
        restart_n = 1'b1;
        stray = 0;
        repeat (60) begin
            @(negedge clka);
            if (done4 !== 1'b0 || busy4 !== 1'b0) stray++;
        end
        chk("abort_no_done", 32'(stray), 0);

        run(0, 47, 0, 0, 0, 5);
        run(0, 47, 0, 0, 1, 0);

        gen_valid(3, 1'b0);
        pack(3);
        run(1, 242, 0, 0, 0, 0);

        for (int it = 0; it < 24; it++) begin
            bx = (it % 6 == 5) ? 3 : 2;
            n = bx * bx;
            gen_valid(bx, 1'b1);
            mode = int'($urandom_range(0, 3));
            if (mode == 1) begin
                cells[$urandom_range(0, n*n-1)] = int'($urandom_range(0, 15));
            end else if (mode >= 2) begin
                a = int'($urandom_range(0, n-1));
                b = (a + int'($urandom_range(1, n-1))) % n;
                k = int'($urandom_range(0, n-1));
                if (mode == 2) begin
                    t = cells[k*n+a]; cells[k*n+a] = cells[k*n+b];
                    cells[k*n+b] = t;
                end else begin
                    t = cells[a*n+k]; cells[a*n+k] = cells[b*n+k];
                    cells[b*n+k] = t;
                end
            end
            pack(bx);
            ref_model(bx, k, idx, pos);
            run(bx == 3 ? 1 : 0, pos, k, idx, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
